// File: rtl/led_blink_pkg.sv
// rtl/led_blink_pkg.sv - shared types and parameter helpers for the LED blink sequencer
//
// Purpose : sequencer state encoding, prescaler divide/width calculation,
//           and the zero-means-one tick length rule.
// Ports   : none (package).

package led_blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } blink_state_t;

  // Clock cycles per blink tick.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed to count 0..div-1, i.e. ceil(log2(div)), never less than 1.
  function automatic int cnt_width(input int div);
    int w;
    w = 1;
    while ((1 << w) < div) begin
      w = w + 1;
    end
    return w;
  endfunction

  // A phase length of 0 ticks is treated as 1 tick.
  function automatic logic [7:0] eff_ticks(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - restartable blink time-base prescaler
//
// Purpose : divides clk_25mhz by DIV and emits a one-cycle tick each time
//           the counter wraps DIV-1 -> 0.
// Ports   : clk_25mhz  in   sole clock
//           rst_n      in   asynchronous active-low reset
//           restart    in   reload the counter to 0 (next tick DIV cycles later)
//           tick       out  one-cycle pulse on wrap

import led_blink_pkg::*;

module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk_25mhz,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int              W    = cnt_width(DIV);
  localparam logic [W-1:0]    LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A restart cycle never counts as a tick: the time base starts fresh.
  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/led_blink_sequencer.sv
// rtl/led_blink_sequencer.sv - command-driven LED blink sequencer
//
// Purpose : accepts one blink command (pattern, on/off length in ticks,
//           repeat count) and plays it out as ON/OFF phases on the led bus.
// Ports   : clk_25mhz      in   sole clock
//           rst_n          in   asynchronous active-low reset
//           cmd_valid      in   command request
//           cmd_ready      out  command can be accepted this cycle
//           cmd_pattern    in   LEDs lit during ON
//           cmd_on_ticks   in   ON length in ticks (0 treated as 1)
//           cmd_off_ticks  in   OFF length in ticks (0 treated as 1)
//           cmd_repeat     in   number of blinks (0 = complete immediately)
//           abort          in   synchronous cancel, no done pulse
//           led            out  registered LED drive
//           busy           out  sequence in progress
//           done           out  one-cycle pulse at normal completion

import led_blink_pkg::*;

module led_blink_sequencer #(
  parameter int CLK_HZ  = 25_000_000,
  parameter int TICK_HZ = 100,
  parameter int LED_W   = 8
) (
  input  logic             clk_25mhz,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LED_W-1:0] cmd_pattern,
  input  logic [7:0]       cmd_on_ticks,
  input  logic [7:0]       cmd_off_ticks,
  input  logic [3:0]       cmd_repeat,
  input  logic             abort,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             done
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

  blink_state_t     state;
  logic [LED_W-1:0] pattern_q;
  logic [7:0]       on_q;
  logic [7:0]       off_q;
  logic [3:0]       rem_q;
  logic [7:0]       phase_cnt;
  logic             out_of_reset;
  logic             tick;
  logic             accept;

  // cmd_ready stays low during reset and rises on the first edge after release.
  assign cmd_ready = out_of_reset && (state == ST_IDLE) && !abort;
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk_25mhz(clk_25mhz),
    .rst_n    (rst_n),
    .restart  (accept),
    .tick     (tick)
  );

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      led       <= '0;
      done      <= 1'b0;
      pattern_q <= '0;
      on_q      <= '0;
      off_q     <= '0;
      rem_q     <= '0;
      phase_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= ST_IDLE;
        led       <= '0;
        rem_q     <= '0;
        phase_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              pattern_q <= cmd_pattern;
              on_q      <= eff_ticks(cmd_on_ticks);
              off_q     <= eff_ticks(cmd_off_ticks);
              rem_q     <= cmd_repeat;
              if (cmd_repeat == 4'd0) begin
                done <= 1'b1;
              end else begin
                state     <= ST_ON;
                led       <= cmd_pattern;
                phase_cnt <= eff_ticks(cmd_on_ticks);
              end
            end
          end

          // phase_cnt holds the ticks still to elapse in the current phase;
          // the phase ends on the tick that finds it at 1.
          ST_ON: begin
            if (tick) begin
              if (phase_cnt == 8'd1) begin
                state     <= ST_OFF;
                led       <= '0;
                phase_cnt <= off_q;
              end else begin
                phase_cnt <= phase_cnt - 8'd1;
              end
            end
          end

          ST_OFF: begin
            if (tick) begin
              if (phase_cnt == 8'd1) begin
                if (rem_q == 4'd1) begin
                  state     <= ST_IDLE;
                  rem_q     <= 4'd0;
                  phase_cnt <= 8'd0;
                  done      <= 1'b1;
                end else begin
                  state     <= ST_ON;
                  rem_q     <= rem_q - 4'd1;
                  led       <= pattern_q;
                  phase_cnt <= on_q;
                end
              end else begin
                phase_cnt <= phase_cnt - 8'd1;
              end
            end
          end

          default: begin
            state <= ST_IDLE;
            led   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// tb/tb_led_blink_sequencer.sv - directed self-checking bench for led_blink_sequencer

module tb_led_blink_sequencer;

  logic       clk_25mhz;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_pattern;
  logic [7:0] cmd_on_ticks;
  logic [7:0] cmd_off_ticks;
  logic [3:0] cmd_repeat;
  logic       abort;
  logic [7:0] led;
  logic       busy;
  logic       done;

  int tests_run = 0;
  int tests_failed = 0;

  led_blink_sequencer #(
    .CLK_HZ (1000),
    .TICK_HZ(100),
    .LED_W  (8)
  ) dut (
    .clk_25mhz    (clk_25mhz),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_pattern  (cmd_pattern),
    .cmd_on_ticks (cmd_on_ticks),
    .cmd_off_ticks(cmd_off_ticks),
    .cmd_repeat   (cmd_repeat),
    .abort        (abort),
    .led          (led),
    .busy         (busy),
    .done         (done)
  );

  initial clk_25mhz = 1'b0;
  always #5 clk_25mhz = ~clk_25mhz;

  // Called at a negedge; returns just after the accept edge.
  task automatic issue_cmd(input logic [7:0] pat, input logic [7:0] on_t,
                           input logic [7:0] off_t, input logic [3:0] rep);
    cmd_pattern   = pat;
    cmd_on_ticks  = on_t;
    cmd_off_ticks = off_t;
    cmd_repeat    = rep;
    cmd_valid     = 1'b1;
    @(posedge clk_25mhz);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cmd_valid = 1'b0; abort = 1'b0;
    cmd_pattern = 8'h00; cmd_on_ticks = 8'd0; cmd_off_ticks = 8'd0; cmd_repeat = 4'd0;
    repeat (3) @(negedge clk_25mhz);
    tests_run++;
    if ({led, busy, done, cmd_ready} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: led=%h busy=%b done=%b ready=%b, need all 0", led, busy, done, cmd_ready);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_before_edge: got %b need 0", cmd_ready);
    end
    @(negedge clk_25mhz);
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_after_edge: got %b need 1", cmd_ready);
    end
  endtask

  task automatic test_basic_blink;
    logic [7:0] exp_led;
    issue_cmd(8'hA5, 8'd2, 8'd3, 4'd2);
    for (int k = 1; k <= 102; k++) begin
      @(negedge clk_25mhz);
      exp_led = ((k >= 1 && k <= 20) || (k >= 51 && k <= 70)) ? 8'hA5 : 8'h00;
      tests_run++;
      if (led !== exp_led || busy !== (k <= 100) || done !== (k == 101)) begin
        tests_failed++;
        $display("FAIL basic_blink cyc%0d: led=%h busy=%b done=%b, need led=%h busy=%b done=%b",
                 k, led, busy, done, exp_led, (k <= 100), (k == 101));
      end
    end
  endtask

  task automatic test_repeat_zero;
    issue_cmd(8'hFF, 8'd4, 8'd4, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_25mhz);
      tests_run++;
      if (led !== 8'h00 || busy !== 1'b0 || done !== (k == 1) || cmd_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL repeat_zero cyc%0d: led=%h busy=%b done=%b ready=%b, need led=00 busy=0 done=%b ready=1",
                 k, led, busy, done, cmd_ready, (k == 1));
      end
    end
  endtask

  task automatic test_zero_ticks;
    logic [7:0] exp_led;
    issue_cmd(8'h3C, 8'd0, 8'd0, 4'd1);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk_25mhz);
      exp_led = (k <= 10) ? 8'h3C : 8'h00;
      tests_run++;
      if (led !== exp_led || busy !== (k <= 20) || done !== (k == 21)) begin
        tests_failed++;
        $display("FAIL zero_ticks cyc%0d: led=%h busy=%b done=%b, need led=%h busy=%b done=%b",
                 k, led, busy, done, exp_led, (k <= 20), (k == 21));
      end
    end
  endtask

  task automatic test_abort;
    issue_cmd(8'h81, 8'd5, 8'd1, 4'd1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk_25mhz);
      tests_run++;
      if (led !== 8'h81 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL abort_pre cyc%0d: led=%h busy=%b, need led=81 busy=1", k, led, busy);
      end
    end
    abort = 1'b1;
    @(negedge clk_25mhz);
    abort = 1'b0;
    tests_run++;
    if (led !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_cut: led=%h busy=%b done=%b, need 00/0/0", led, busy, done);
    end
    for (int k = 17; k <= 70; k++) begin
      @(negedge clk_25mhz);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0 || led !== 8'h00) begin
        tests_failed++;
        $display("FAIL abort_quiet cyc%0d: led=%h busy=%b done=%b, need 00/0/0", k, led, busy, done);
      end
    end
    // abort together with cmd_valid in IDLE: no accept
    abort = 1'b1;
    cmd_pattern = 8'hC3; cmd_on_ticks = 8'd1; cmd_off_ticks = 8'd1; cmd_repeat = 4'd0;
    cmd_valid = 1'b1;
    #1;
    tests_run++;
    if (cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_ready: got %b need 0", cmd_ready);
    end
    @(negedge clk_25mhz);
    abort = 1'b0;
    cmd_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || led !== 8'h00 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_vs_valid: busy=%b led=%h done=%b, need 0/00/0", busy, led, done);
    end
  endtask

  task automatic test_ignore_busy;
    logic [7:0] exp_led;
    issue_cmd(8'h5A, 8'd1, 8'd1, 4'd2);
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk_25mhz);
      if (k == 5) begin
        cmd_pattern = 8'hFF; cmd_on_ticks = 8'd0; cmd_off_ticks = 8'd9; cmd_repeat = 4'd5;
        cmd_valid = 1'b1;
      end else if (k == 6) begin
        cmd_valid = 1'b0;
      end
      exp_led = ((k <= 10) || (k >= 21 && k <= 30)) ? 8'h5A : 8'h00;
      tests_run++;
      if (led !== exp_led || busy !== (k <= 40) || done !== (k == 41)) begin
        tests_failed++;
        $display("FAIL ignore_busy cyc%0d: led=%h busy=%b done=%b, need led=%h busy=%b done=%b",
                 k, led, busy, done, exp_led, (k <= 40), (k == 41));
      end
    end
  endtask

  task automatic test_reset_mid;
    issue_cmd(8'h77, 8'd1, 8'd3, 4'd1);
    repeat (20) @(negedge clk_25mhz);
    tests_run++;
    if (led !== 8'h00 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_pre: led=%h busy=%b, need 00/1 (OFF)", led, busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({led, busy, done, cmd_ready} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: led=%h busy=%b done=%b ready=%b, need all 0", led, busy, done, cmd_ready);
    end
    repeat (3) @(negedge clk_25mhz);
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_25mhz);
      tests_run++;
      if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || led !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_mid_after cyc%0d: ready=%b done=%b busy=%b led=%h, need 1/0/0/00",
                 k, cmd_ready, done, busy, led);
      end
    end
  endtask

  task automatic test_back_to_back;
    issue_cmd(8'h0F, 8'd1, 8'd1, 4'd1);
    repeat (20) @(negedge clk_25mhz);
    @(negedge clk_25mhz);
    tests_run++;
    if (done !== 1'b1 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_done_ready: done=%b ready=%b, need 1/1", done, cmd_ready);
    end
    issue_cmd(8'hF0, 8'd1, 8'd1, 4'd1);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk_25mhz);
      tests_run++;
      if (led !== ((k <= 10) ? 8'hF0 : 8'h00) || busy !== (k <= 20) || done !== (k == 21)) begin
        tests_failed++;
        $display("FAIL b2b_second cyc%0d: led=%h busy=%b done=%b, need led=%h busy=%b done=%b",
                 k, led, busy, done, ((k <= 10) ? 8'hF0 : 8'h00), (k <= 20), (k == 21));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_blink();
    test_repeat_zero();
    test_zero_ticks();
    test_abort();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
